// File: rtl/divider_32.sv
// divider_32: 32-bit signed non-restoring divider, 33-cycle latency, divide-by-zero flag.
module divider_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [32:0] r, rn;
  logic [31:0] q, bmag, amag_in, bmag_in;
  logic [64:0] sh;
  logic        sa, sb;
  logic [5:0]  cnt;
  assign amag_in = data_operandA[31] ? -data_operandA : data_operandA;
  assign bmag_in = data_operandB[31] ? -data_operandB : data_operandB;
  assign sh = {r, q} << 1;
  // R is signed; the sign of the previous partial remainder picks add or subtract
  assign rn = r[32] ? sh[64:32] + {1'b0, bmag} : sh[64:32] - {1'b0, bmag};
  always_comb begin
    state_n = state;
    if (ctrl_DIV) state_n = (data_operandB == 32'd0) ? DONE : RUN;
    else if (state == RUN && cnt == 6'd31) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r <= '0;
      q <= '0;
      bmag <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      cnt <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        r <= '0;
        q <= amag_in;
        bmag <= bmag_in;
        sa <= data_operandA[31];
        sb <= data_operandB[31];
        cnt <= '0;
      end else if (state == RUN) begin
        r <= rn;
        q <= {q[30:0], ~rn[32]};
        cnt <= cnt + 6'd1;
      end else if (state == DONE) begin
        r <= r[32] ? r + {1'b0, bmag} : r;
        data_result <= (bmag == 32'd0) ? 32'd0 : ((sa ^ sb) ? -q : q);
        data_exception <= (bmag == 32'd0);
        data_resultRDY <= 1'b1;
      end
    end
  end
endmodule

// File: doc/divider_32.md
DIVIDER_32 -- requirements
Module: divider_32

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, listed first:
- clock  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high reset
REQ-002 The module SHALL have these data and control ports:
- data_operandA  input  32  dividend, two's complement
- data_operandB  input  32  divisor, two's complement
- ctrl_DIV  input  1  start pulse; sampled on the rising edge
- data_result  output  32  signed quotient
- data_exception  output  1  divide-by-zero flag
- data_resultRDY  output  1  one-cycle completion strobe
REQ-003 The module SHALL have no parameters; all widths are fixed at 32 bits.

Function
REQ-004 Internal state SHALL be:
- a 65-bit working register {R[32:0], Q[31:0]} built from enable/clear flip-flops
- a latched 32-bit divisor magnitude
- two latched sign bits
- a 6-bit iteration counter
- FSM states IDLE, RUN, DONE
REQ-005 An edge k with ctrl_DIV=1 SHALL, from any state:
- latch |A| into Q and clear R
- latch |B|, sign(A) and sign(B)
- clear the counter
- enter RUN; if B==0, enter DONE instead
REQ-006 Each RUN edge SHALL perform one non-restoring iteration:
- shift {R,Q} left by 1
- add |B| to R if R was negative, otherwise subtract |B|
- set Q[0] = ~R[32] of the new R
- increment the counter
REQ-007 On the 32nd RUN iteration, edge k+32, the FSM SHALL enter DONE.
REQ-008 The DONE edge, k+33, SHALL register the outputs:
- apply the final restore if needed
- data_result = Q, negated if sign(A) XOR sign(B)
- pulse data_resultRDY=1 for exactly one cycle
- return to IDLE
REQ-009 Quotients SHALL truncate toward zero; the remainder is discarded.
REQ-010 Division by zero SHALL complete at edge k+1 with data_result=0, data_exception=1 and data_resultRDY=1 for one cycle.
REQ-011 0x80000000 / 0xFFFFFFFF SHALL yield data_result=0x80000000 with data_exception=0 (wrap, not flagged).
REQ-012 data_result and data_exception SHALL hold their values until the next completion or reset; data_exception clears on the next non-zero-divisor completion.
REQ-013 ctrl_DIV asserted during RUN SHALL abort the operation in flight without a data_resultRDY pulse, then restart per REQ-005 with the new operands.
REQ-014 ctrl_DIV asserted in the same cycle that data_resultRDY is high SHALL start a new operation; the pulse for the finished operation still occurs.
REQ-015 Operand inputs SHALL be ignored except on edges where ctrl_DIV=1.
REQ-016 data_resultRDY SHALL never be high for two consecutive cycles.

Reset
REQ-017 Asserting reset SHALL immediately, without waiting for a clock edge:
- set the FSM to IDLE
- clear the 65-bit register, counter and sign bits
- force data_result=0, data_exception=0, data_resultRDY=0
REQ-018 Reset asserted mid-RUN SHALL discard the operation, with no data_resultRDY pulse after release.
REQ-019 The first edge after reset release with ctrl_DIV=1 SHALL start normally per REQ-005.

Verification
REQ-020 A=100, B=7, ctrl_DIV at edge k: data_resultRDY=1 only in the cycle after edge k+33, data_result=14, data_exception=0.
REQ-021 A=-100 (0xFFFFFF9C), B=7: data_result=0xFFFFFFF2 (-14); then A=100, B=-7 -> 0xFFFFFFF2; then A=-100, B=-7 -> 14.
REQ-022 A=5, B=0: data_resultRDY=1 and data_exception=1 after edge k+1, data_result=0; then A=9, B=3 -> data_result=3, data_exception=0.
REQ-023 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=0; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF; A=3, B=5 -> 0.
REQ-024 A=1000, B=10 started at edge k, then A=81, B=9 with ctrl_DIV at k+10:
- no data_resultRDY pulse for the first operation
- data_result=9 after edge k+43
REQ-025 Start A=50, B=5 and assert reset at k+15 for 2 cycles:
- outputs go to 0 asynchronously
- no data_resultRDY pulse follows
- a new start with A=50, B=5 yields 10 after 33 edges
